// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the MIPS data-memory bus.
// Stores to TX_DATA_ADDR queue bytes in a small FIFO; loads from STATUS_ADDR return a polled status word.
module mmio_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter logic [31:0] TX_DATA_ADDR = 32'h1001_0024,
  parameter logic [31:0] STATUS_ADDR  = 32'h1001_0028
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  output logic [31:0] ReadData,
  output logic        TxSerial,
  output logic        TxBusy,
  output logic        FifoFull
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned BW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} txState_t;

  txState_t      state;
  logic [7:0]    fifoMem [FIFO_DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] count;
  logic [CW-1:0] countNext;
  logic          overflow;
  logic [7:0]    shiftReg;
  logic [2:0]    bitIdx;
  logic [BW-1:0] baudCnt;

  logic pushReq;
  logic ctrlWrite;
  logic pushAccept;
  logic fifoHasData;
  logic baudDone;
  logic pop;
  logic [2:0] countField;
  logic unusedWriteBits;

  assign pushReq     = MemWrite && (Address == TX_DATA_ADDR);
  assign ctrlWrite   = MemWrite && (Address == STATUS_ADDR);
  assign fifoHasData = (count != '0);
  assign baudDone    = (baudCnt == BW'(CLKS_PER_BIT - 1));
  // Full is judged on the pre-edge count, so a pop in the same cycle never makes room for a push.
  assign pushAccept  = pushReq && (count != CW'(FIFO_DEPTH));
  // Pops happen from IDLE or on the final STOP cycle, which chains frames without an idle gap.
  assign pop         = fifoHasData && ((state == IDLE) || ((state == STOP) && baudDone));
  assign countField  = 3'(count);
  assign unusedWriteBits = ^WriteData[31:8];

  always_comb begin
    countNext = count;
    case ({pushAccept, pop})
      2'b10:   countNext = count + 1'b1;
      2'b01:   countNext = count - 1'b1;
      default: countNext = count;
    endcase
  end

  always_comb begin
    ReadData = '0;
    if (MemRead && (Address == STATUS_ADDR))
      ReadData = {21'b0, countField, 4'b0, overflow, ~fifoHasData, FifoFull, TxBusy};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      TxSerial <= 1'b1;
      TxBusy   <= 1'b0;
      FifoFull <= 1'b0;
      count    <= '0;
      wptr     <= '0;
      rptr     <= '0;
      overflow <= 1'b0;
      shiftReg <= '0;
      bitIdx   <= '0;
      baudCnt  <= '0;
    end else begin
      if (pushAccept) begin
        fifoMem[wptr] <= WriteData[7:0];
        wptr          <= wptr + 1'b1;
      end

      if (pushReq && !pushAccept)
        overflow <= 1'b1;
      else if (ctrlWrite && WriteData[3])
        overflow <= 1'b0;

      count    <= countNext;
      FifoFull <= (countNext == CW'(FIFO_DEPTH));

      if (pop) begin
        shiftReg <= fifoMem[rptr];
        rptr     <= rptr + 1'b1;
      end

      case (state)
        IDLE: begin
          TxSerial <= 1'b1;
          baudCnt  <= '0;
          if (pop) begin
            state    <= START;
            TxSerial <= 1'b0;
            TxBusy   <= 1'b1;
          end
        end
        START: begin
          if (baudDone) begin
            baudCnt  <= '0;
            bitIdx   <= '0;
            state    <= DATA;
            TxSerial <= shiftReg[0];
          end else begin
            baudCnt <= baudCnt + 1'b1;
          end
        end
        DATA: begin
          if (baudDone) begin
            baudCnt <= '0;
            if (bitIdx == 3'd7) begin
              state    <= STOP;
              TxSerial <= 1'b1;
            end else begin
              bitIdx   <= bitIdx + 1'b1;
              TxSerial <= shiftReg[bitIdx + 3'd1];
            end
          end else begin
            baudCnt <= baudCnt + 1'b1;
          end
        end
        STOP: begin
          if (baudDone) begin
            baudCnt <= '0;
            if (pop) begin
              state    <= START;
              TxSerial <= 1'b0;
            end else begin
              state    <= IDLE;
              TxSerial <= 1'b1;
              TxBusy   <= 1'b0;
            end
          end else begin
            baudCnt <= baudCnt + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          TxSerial <= 1'b1;
          TxBusy   <= 1'b0;
        end
      endcase
    end
  end

endmodule
